// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between primary writeback and a queued
// long-latency result stream, and scoreboards outstanding long-latency writes.
module rf_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pri_valid,
  input  logic [4:0]  pri_rd,
  input  logic [31:0] pri_data,
  input  logic        sec_valid,
  output logic        sec_ready,
  input  logic [4:0]  sec_rd,
  input  logic [31:0] sec_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        busy1,
  output logic        busy2,
  output logic        pri_hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);
  localparam int StW  = $clog2(STARVE_MAX + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [StW-1:0]  StarveC = StW'(STARVE_MAX);

  logic [4:0]      qRd   [DEPTH];
  logic [31:0]     qData [DEPTH];
  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;
  logic [CntW-1:0] count;
  logic [CntW-1:0] countNext;
  logic [StW-1:0]  starveCnt;
  logic [StW-1:0]  starveInc;
  logic [31:0]     pending;
  logic [31:0]     pendingNext;
  logic [31:0]     setMask;
  logic [31:0]     clearMask;
  logic [4:0]      headRd;
  logic [31:0]     headData;
  logic            queueNonEmpty;
  logic            priReq;
  logic            popSel;
  logic            priSel;
  logic            pushEn;
  logic            setEn;

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign sec_ready   = (count < DepthC);
  assign issue_stall = issue_valid & pending[issue_rd] & (issue_rd != 5'd0);
  assign busy1       = pending[rs1] & (rs1 != 5'd0);
  assign busy2       = pending[rs2] & (rs2 != 5'd0);

  always_comb begin
    queueNonEmpty = (count != '0);
    priReq        = pri_valid & (pri_rd != 5'd0);
    // A forced drain or an idle primary lets the queue head through.
    popSel        = queueNonEmpty & (pri_hold | ~priReq);
    priSel        = priReq & ~popSel;
    pushEn        = sec_valid & sec_ready & (sec_rd != 5'd0);
    headRd        = qRd[headPtr];
    headData      = qData[headPtr];
    setEn         = issue_valid & ~issue_stall & (issue_rd != 5'd0);
    setMask       = setEn ? (32'd1 << issue_rd) : 32'd0;
    clearMask     = popSel ? (32'd1 << headRd) : 32'd0;
    pendingNext   = (pending & ~clearMask) | setMask;
    starveInc     = starveCnt + 1'b1;
    countNext     = count;
    case ({pushEn, popSel})
      2'b10:   countNext = count + 1'b1;
      2'b01:   countNext = count - 1'b1;
      default: countNext = count;
    endcase
  end

  // Queue storage is plain memory; only the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      qRd[tailPtr]   <= sec_rd;
      qData[tailPtr] <= sec_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      starveCnt <= '0;
      pending   <= '0;
      pri_hold  <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= 5'd0;
      rf_wdata  <= 32'd0;
    end else begin
      count   <= countNext;
      pending <= pendingNext;
      if (popSel) headPtr <= incPtr(headPtr);
      if (pushEn) tailPtr <= incPtr(tailPtr);

      if (popSel) begin
        rf_we    <= 1'b1;
        rf_waddr <= headRd;
        rf_wdata <= headData;
      end else if (priSel) begin
        rf_we    <= 1'b1;
        rf_waddr <= pri_rd;
        rf_wdata <= pri_data;
      end else begin
        rf_we    <= 1'b0;
      end

      pri_hold <= 1'b0;
      if (popSel || !queueNonEmpty) begin
        starveCnt <= '0;
      end else if (priSel) begin
        if (starveInc == StarveC) begin
          pri_hold  <= 1'b1;
          starveCnt <= '0;
        end else begin
          starveCnt <= starveInc;
        end
      end
    end
  end

endmodule
